sra_op_issuer: RTL and testbench

//  Upstream feeder for the signed arithmetic right shifter (SRA). Buffers operand pairs arriving on a

---
 rtl/sra_issue_pkg.sv | 14 +
 rtl/sra_cmd_fifo.sv | 47 ++++
 rtl/sra_op_issuer.sv | 138 +++++++++++++
 tb/tb_sra_op_issuer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sra_issue_pkg.sv
// rtl/sra_issue_pkg.sv - shared FSM encoding and default sizes for the SRA operand issuer
package sra_issue_pkg;

    localparam int SRA_WIDTH_DEF   = 8;
    localparam int SRA_DEPTH_DEF   = 4;
    localparam int SRA_LATENCY_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } sra_state_e;

endpackage

// File: rtl/sra_cmd_fifo.sv
// rtl/sra_cmd_fifo.sv - synchronous operand FIFO with combinational head read
module sra_cmd_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          pop_i,
    output logic [DW-1:0] pop_data_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointers wrap naturally; the extra count bit separates full from empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push_i && !pop_i)      count_q <= count_q + (AW+1)'(1);
            else if (pop_i && !push_i) count_q <= count_q - (AW+1)'(1);
        end
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign full_o     = (count_q == (AW+1)'(DEPTH));
    assign empty_o    = (count_q == '0);

endmodule

// File: rtl/sra_op_issuer.sv
// rtl/sra_op_issuer.sv - feeds operand pairs to the SRA shifter one at a time and returns results in order
// Optional stats counters: define SRA_ISSUE_STATS_EN
module sra_op_issuer
    import sra_issue_pkg::*;
#(
    parameter int WIDTH       = SRA_WIDTH_DEF,
    parameter int DEPTH       = SRA_DEPTH_DEF,
    parameter int SRA_LATENCY = SRA_LATENCY_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] in_shamt,
    output logic [WIDTH-1:0] sra_input1,
    output logic [WIDTH-1:0] sra_input2,
    output logic             sra_start,
    input  logic [WIDTH-1:0] sra_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             busy
`ifdef SRA_ISSUE_STATS_EN
    ,
    output logic [15:0]      issued_cnt,
    output logic [15:0]      stall_cnt
`endif
);

    localparam int CW = (SRA_LATENCY > 1) ? $clog2(SRA_LATENCY) : 1;

    sra_state_e         state_q, state_d;
    logic [CW-1:0]      lat_q, lat_d;
    logic [WIDTH-1:0]   in1_q, in2_q, result_q;
    logic               start_q, out_valid_q, rdy_q;
    logic               fifo_full, fifo_empty, push, pop, capture;
    logic [2*WIDTH-1:0] fifo_head;

    // rdy_q keeps in_ready low during reset and for the first cycle after it.
    assign in_ready = rdy_q && !fifo_full;
    assign push     = in_valid && in_ready;

    sra_cmd_fifo #(
        .DW    (2*WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i ({in_data, in_shamt}),
        .pop_i       (pop),
        .pop_data_o  (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        pop     = 1'b0;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && (!out_valid_q || out_ready)) begin
                    pop     = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                state_d = ST_WAIT;
                lat_d   = CW'(SRA_LATENCY - 1);
            end
            ST_WAIT: begin
                if (lat_q == '0) begin
                    capture = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    lat_d = lat_q - CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The output slot is always empty during WAIT, so capture never meets a pending result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            lat_q       <= '0;
            in1_q       <= '0;
            in2_q       <= '0;
            start_q     <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            rdy_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            rdy_q   <= 1'b1;
            start_q <= pop;
            if (pop) begin
                {in1_q, in2_q} <= fifo_head;
            end
            if (capture) begin
                result_q    <= sra_result;
                out_valid_q <= 1'b1;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign sra_input1 = in1_q;
    assign sra_input2 = in2_q;
    assign sra_start  = start_q;
    assign out_valid  = out_valid_q;
    assign out_result = result_q;
    assign busy       = (state_q != ST_IDLE) || !fifo_empty;

`ifdef SRA_ISSUE_STATS_EN
    logic [15:0] issued_q, stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            issued_q <= '0;
            stall_q  <= '0;
        end else begin
            if (start_q)                   issued_q <= issued_q + 16'd1;
            if (out_valid_q && !out_ready) stall_q  <= stall_q + 16'd1;
        end
    end

    assign issued_cnt = issued_q;
    assign stall_cnt  = stall_q;
`endif

endmodule

// File: tb/tb_sra_op_issuer.sv
// tb/tb_sra_op_issuer.sv - scoreboard bench for sra_op_issuer with a behavioural SRA shifter model
module tb_sra_op_issuer;

    localparam int W = 8;
    localparam int D = 4;
    localparam int L = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] in_data = '0;
    logic [W-1:0] in_shamt = '0;
    logic [W-1:0] sra_result;
    wire          in_ready, sra_start, out_valid, busy;
    wire  [W-1:0] sra_input1, sra_input2, out_result;
`ifdef SRA_ISSUE_STATS_EN
    wire  [15:0]  issued_cnt, stall_cnt;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int start_cyc = 0;
    int n_start = 0;
    int stall_exp = 0;
    bit prev_start = 1'b0;
    bit prev_ov = 1'b0;
    logic [W-1:0]   exp_q[$];
    logic [2*W-1:0] iss_q[$];
    logic [3:0]     shl_cnt = '0;

    sra_op_issuer #(.WIDTH(W), .DEPTH(D), .SRA_LATENCY(L)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_shamt   (in_shamt),
        .sra_input1 (sra_input1),
        .sra_input2 (sra_input2),
        .sra_start  (sra_start),
        .sra_result (sra_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .busy       (busy)
`ifdef SRA_ISSUE_STATS_EN
        ,
        .issued_cnt (issued_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    always #10 clk = ~clk;

    function automatic logic [W-1:0] sra_f(input logic [W-1:0] a, input logic [W-1:0] s);
        logic signed [W-1:0] t;
        t = a;
        return t >>> s;
    endfunction

    // Shifter model: result is only valid in cycle T+L after the Start cycle T; junk otherwise.
    always @(posedge clk) begin
        if (sra_start) shl_cnt <= 4'd1;
        else if (shl_cnt != 0 && shl_cnt < L) shl_cnt <= shl_cnt + 4'd1;
    end
    always_comb sra_result = (shl_cnt == L) ? sra_f(sra_input1, sra_input2) : 8'hA5;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: all DUT sampling happens on the falling edge.
    always @(negedge clk) begin
        logic [2*W-1:0] op;
        logic [W-1:0]   r;
        if (!rst) begin
            if (sra_start) begin
                chk("start_one_cycle", prev_start, 0);
                n_start++;
                start_cyc = cyc;
                if (iss_q.size() != 0) begin
                    op = iss_q.pop_front();
                    chk("sra_input1", sra_input1, op[2*W-1:W]);
                    chk("sra_input2", sra_input2, op[W-1:0]);
                end else begin
                    chk("start_has_op", iss_q.size(), 1);
                end
            end
            if (out_valid && !prev_ov) chk("result_latency", cyc - start_cyc, L + 1);
            if (out_valid && out_ready) begin
                if (exp_q.size() != 0) begin
                    r = exp_q.pop_front();
                    chk("out_result", out_result, r);
                end else begin
                    chk("result_expected", exp_q.size(), 1);
                end
            end
            if (out_valid && !out_ready) stall_exp++;
        end
        prev_start = sra_start;
        prev_ov    = out_valid;
    end

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        step();
        exp_q.delete();
        iss_q.delete();
        stall_exp = 0;
        rst = 1'b0;
    endtask

    task automatic push(input logic [W-1:0] d, input logic [W-1:0] s, input logic [W-1:0] e, input bit rnd);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = s;
        while (!in_ready && n < 200) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        chk("push_accepted", n < 200, 1);
        iss_q.push_back({d, s});
        exp_q.push_back(e);
        if (rnd) out_ready = 1'($urandom_range(0, 1));
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy || out_valid) && n < 300) begin
            step();
            n++;
        end
        chk(tag, n < 300, 1);
    endtask

    initial begin
        #5ms;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int acc, s0;
        logic [W-1:0] d, s;

        // Reset state
        step();
        step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sra_start", sra_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_sra_input1", sra_input1, 0);
        chk("rst_out_result", out_result, 0);
        rst = 1'b0;
        chk("in_ready_first_cycle", in_ready, 0);
        step();
        chk("in_ready_after_rst", in_ready, 1);

        // Test 1: single op
        out_ready = 1'b1;
        s0 = n_start;
        push(8'd3, 8'd4, 8'h00, 1'b0);
        chk("busy_after_push", busy, 1);
        wait_idle("t1_idle");
        chk("t1_start_count", n_start - s0, 1);

        // Test 2: sign preservation
        push(8'hF0, 8'd2, 8'hFC, 1'b0);
        push(8'h80, 8'd7, 8'hFF, 1'b0);
        wait_idle("t2_idle");
        chk("t2_drained", exp_q.size(), 0);

        // Test 3: output stalled, fill FIFO
        out_ready = 1'b0;
        acc = 0;
        s0 = n_start;
        for (int k = 0; k < 20; k++) begin
            d = {acc[0], 7'h35};
            s = 8'(acc);
            in_valid = 1'b1;
            in_data  = d;
            in_shamt = s;
            if (in_ready) begin
                iss_q.push_back({d, s});
                exp_q.push_back(sra_f(d, s));
                acc++;
            end
            step();
        end
        in_valid = 1'b0;
        chk("t3_accepted", acc, D + 1);
        chk("t3_in_ready", in_ready, 0);
        chk("t3_starts", n_start - s0, 1);
        chk("t3_out_valid_held", out_valid, 1);

        // Test 4: release output, drain in order
        out_ready = 1'b1;
        step();
        chk("t4_in_ready_after_pop", in_ready, 1);
        wait_idle("t4_idle");
        chk("t4_drained", exp_q.size(), 0);

        // Test 5: reset during WAIT
        push(8'h55, 8'd1, 8'h2A, 1'b0);
        begin
            int n = 0;
            while (!sra_start && n < 50) begin step(); n++; end
            chk("t5_start_seen", n < 50, 1);
        end
        step();
        do_reset();
        chk("t5_out_valid", out_valid, 0);
        chk("t5_sra_start", sra_start, 0);
        chk("t5_busy", busy, 0);
        for (int k = 0; k < 8; k++) begin
            step();
            chk("t5_no_stale_result", out_valid, 0);
        end
        chk("t5_in_ready", in_ready, 1);

        // Test 6: stream with random backpressure
        do_reset();
        step();
        for (int i = 0; i < 10; i++) begin
            d = 8'($urandom);
            s = 8'($urandom_range(0, 9));
            push(d, s, sra_f(d, s), 1'b1);
        end
        begin
            int n = 0;
            while ((busy || out_valid) && n < 400) begin
                out_ready = 1'($urandom_range(0, 1));
                step();
                n++;
            end
        end
        out_ready = 1'b1;
        wait_idle("t6_idle");
        chk("t6_drained", exp_q.size(), 0);
        chk("t6_issued_all", iss_q.size(), 0);
`ifdef SRA_ISSUE_STATS_EN
        chk("t6_issued_cnt", issued_cnt, 10);
        chk("t6_stall_cnt", stall_cnt, 16'(stall_exp));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
